// File: rtl/arp_tx_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : arp_tx_gen_if
//  Description : Request, stream and status bundle for the ARP frame builder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface arp_tx_gen_if;
    logic        arp_tx_en;
    logic [1:0]  arp_tx_op;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        arp_tx_ready;
    logic        arp_tx_busy;
    logic [7:0]  arp_tx_data;
    logic        arp_tx_valid;
    logic        arp_tx_done;
    logic [15:0] tx_frame_cnt;

    modport master (
        output arp_tx_en, arp_tx_op, des_mac, des_ip, local_mac, local_ip,
        input  arp_tx_ready, arp_tx_busy, arp_tx_data, arp_tx_valid,
               arp_tx_done, tx_frame_cnt
    );

    modport slave (
        input  arp_tx_en, arp_tx_op, des_mac, des_ip, local_mac, local_ip,
        output arp_tx_ready, arp_tx_busy, arp_tx_data, arp_tx_valid,
               arp_tx_done, tx_frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/arp_tx_gen.sv
`default_nettype none
// ============================================================================
//  Module      : arp_tx_gen
//  Description : Byte-serial Ethernet II + ARP frame builder with CRC-32 FCS.
//  Revision    : 1.0 - initial release
// ============================================================================
module arp_tx_gen #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int PAD_BYTES      = 18,
    parameter int IFG_BYTES      = 12
) (
    input  wire           arp_tx_clk,
    input  wire           rstn,
    arp_tx_gen_if.slave   bus
);

    localparam logic [7:0] c_pre_last = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] c_hdr_last = 8'd41;
    localparam logic [7:0] c_pad_last = 8'(PAD_BYTES - 1);
    localparam logic [7:0] c_ifg_last = 8'(IFG_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_HDR      = 3'd3,
        S_PAD      = 3'd4,
        S_FCS      = 3'd5,
        S_IFG      = 3'd6
    } state_t;

    state_t       r_state;
    logic [7:0]   r_cnt;
    logic [335:0] r_hdr;
    logic [31:0]  r_crc;
    logic [7:0]   r_data;
    logic         r_valid;
    logic         r_done;
    logic         r_ready;
    logic         r_busy;
    logic [15:0]  r_frame_cnt;

    logic         w_is_reply;
    logic         w_is_grat;
    logic [47:0]  w_dst;
    logic [47:0]  w_tha;
    logic [31:0]  w_tpa;
    logic [335:0] w_hdr_in;
    logic [31:0]  w_crc_next;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // Whole 42-byte header is assembled at accept and shifted out MSB first
    assign w_is_reply = (bus.arp_tx_op == 2'd0);
    assign w_is_grat  = (bus.arp_tx_op == 2'd2);
    assign w_dst      = w_is_reply ? bus.des_mac : 48'hFFFF_FFFF_FFFF;
    assign w_tha      = w_is_reply ? bus.des_mac : 48'h0;
    assign w_tpa      = w_is_grat  ? bus.local_ip : bus.des_ip;
    assign w_hdr_in   = {w_dst, bus.local_mac, 64'h0806_0001_0800_0604,
                         8'h00, (w_is_reply ? 8'h02 : 8'h01),
                         bus.local_mac, bus.local_ip, w_tha, w_tpa};

    // r_data holds the byte on the wire, so it is what gets folded into the CRC
    assign w_crc_next = crc32_byte(r_crc, r_data);

    always_ff @(posedge arp_tx_clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_hdr       <= '0;
            r_crc       <= 32'hFFFF_FFFF;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_ready && bus.arp_tx_en) begin
                        r_state <= S_PREAMBLE;
                        r_cnt   <= 8'd0;
                        r_hdr   <= w_hdr_in;
                        r_crc   <= 32'hFFFF_FFFF;
                        r_data  <= 8'h55;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    if (r_cnt == c_pre_last) begin
                        r_state <= S_SFD;
                        r_data  <= 8'hD5;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SFD: begin
                    r_state <= S_HDR;
                    r_cnt   <= 8'd0;
                    r_data  <= r_hdr[335:328];
                    r_hdr   <= r_hdr << 8;
                end
                S_HDR: begin
                    r_crc <= w_crc_next;
                    if (r_cnt == c_hdr_last) begin
                        r_cnt <= 8'd0;
                        if (PAD_BYTES == 0) begin
                            r_state <= S_FCS;
                            r_data  <= ~w_crc_next[7:0];
                            r_crc   <= w_crc_next >> 8;
                        end else begin
                            r_state <= S_PAD;
                            r_data  <= 8'h00;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_data <= r_hdr[335:328];
                        r_hdr  <= r_hdr << 8;
                    end
                end
                S_PAD: begin
                    r_crc <= w_crc_next;
                    if (r_cnt == c_pad_last) begin
                        r_state <= S_FCS;
                        r_cnt   <= 8'd0;
                        r_data  <= ~w_crc_next[7:0];
                        r_crc   <= w_crc_next >> 8;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_FCS: begin
                    if (r_cnt == 8'd3) begin
                        r_state <= S_IFG;
                        r_cnt   <= 8'd0;
                        r_data  <= 8'h00;
                        r_valid <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_data <= ~r_crc[7:0];
                        r_crc  <= r_crc >> 8;
                        if (r_cnt == 8'd2) begin
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end
                end
                S_IFG: begin
                    if (r_cnt == c_ifg_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                    r_data  <= 8'h00;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arp_tx_ready = r_ready;
    assign bus.arp_tx_busy  = r_busy;
    assign bus.arp_tx_data  = r_data;
    assign bus.arp_tx_valid = r_valid;
    assign bus.arp_tx_done  = r_done;
    assign bus.tx_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arp_tx_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arp_tx_gen
//  Description : Directed bench for arp_tx_gen (default and minimal parameter sets).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_arp_tx_gen;

    localparam int          IFG  = 12;
    localparam logic [47:0] LMAC = 48'h0011_2233_4455;
    localparam logic [31:0] LIP  = 32'hC0A8_0003;

    logic arp_tx_clk = 1'b0;
    logic rstn;
    always #5 arp_tx_clk = ~arp_tx_clk;

    arp_tx_gen_if bus ();
    arp_tx_gen_if bus_s ();

    arp_tx_gen #(.PREAMBLE_BYTES(7), .PAD_BYTES(18), .IFG_BYTES(IFG)) dut (
        .arp_tx_clk (arp_tx_clk),
        .rstn       (rstn),
        .bus        (bus)
    );

    arp_tx_gen #(.PREAMBLE_BYTES(1), .PAD_BYTES(0), .IFG_BYTES(1)) dut_s (
        .arp_tx_clk (arp_tx_clk),
        .rstn       (rstn),
        .bus        (bus_s)
    );

    logic        sel;
    logic        mon_valid, mon_done, mon_ready, mon_busy;
    logic [7:0]  mon_data;
    logic [15:0] mon_cnt;
    assign mon_valid = sel ? bus_s.arp_tx_valid : bus.arp_tx_valid;
    assign mon_done  = sel ? bus_s.arp_tx_done  : bus.arp_tx_done;
    assign mon_ready = sel ? bus_s.arp_tx_ready : bus.arp_tx_ready;
    assign mon_busy  = sel ? bus_s.arp_tx_busy  : bus.arp_tx_busy;
    assign mon_data  = sel ? bus_s.arp_tx_data  : bus.arp_tx_data;
    assign mon_cnt   = sel ? bus_s.tx_frame_cnt : bus.tx_frame_cnt;

    typedef struct {
        logic [1:0]  op;
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [47:0] e_dst;
        logic [15:0] e_opc;
        logic [47:0] e_tha;
        logic [31:0] e_tpa;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] cap[$];
    logic [7:0] gold[$];
    int         cap_done;
    int         n_cmp;
    int         n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    task automatic push_be(input logic [47:0] v, input int nbytes);
        for (int k = nbytes - 1; k >= 0; k--) gold.push_back(v[8*k +: 8]);
    endtask

    function automatic logic [47:0] cap_be(input int start, input int n);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r = {r[39:0], cap[start + k]};
        return r;
    endfunction

    // Reference frame: preamble/SFD, fixed ARP layout, pad, then ~CRC LSB first
    task automatic build_gold(input vec_t v, input int pre, input int pad);
        logic [31:0] c;
        gold = {};
        for (int i = 0; i < pre; i++) gold.push_back(8'h55);
        gold.push_back(8'hD5);
        push_be(v.e_dst, 6);
        push_be(LMAC, 6);
        push_be(48'h0806_0001, 4);
        push_be(48'h0800_0604, 4);
        push_be({32'h0, v.e_opc}, 2);
        push_be(LMAC, 6);
        push_be({16'h0, LIP}, 4);
        push_be(v.e_tha, 6);
        push_be({16'h0, v.e_tpa}, 4);
        for (int i = 0; i < pad; i++) gold.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = pre + 1; i < gold.size(); i++) c = crc_upd(c, gold[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) gold.push_back(c[8*k +: 8]);
    endtask

    task automatic capture();
        int t;
        cap = {};
        cap_done = -1;
        t = 0;
        while (!mon_valid && t < 100) begin @(negedge arp_tx_clk); t++; end
        while (mon_valid && cap.size() < 200) begin
            if (mon_done) cap_done = cap.size();
            cap.push_back(mon_data);
            @(negedge arp_tx_clk);
        end
        chk("idle_data_zero", 64'(mon_data), 64'h0);
    endtask

    task automatic check_frame(input string tag, input vec_t v, input int pre, input int pad);
        int          n, nbad, h;
        logic [31:0] c, rev;
        build_gold(v, pre, pad);
        n = gold.size();
        chk({tag, "_len"}, 64'(cap.size()), 64'(n));
        chk({tag, "_done_idx"}, 64'(cap_done), 64'(n - 1));
        if (cap.size() == n) begin
            h = pre + 1;
            nbad = 0;
            for (int i = 0; i < n - 4; i++) if (cap[i] !== gold[i]) nbad++;
            chk({tag, "_body_bad_bytes"}, 64'(nbad), 64'h0);
            chk({tag, "_dst"}, 64'(cap_be(h, 6)), 64'(v.e_dst));
            chk({tag, "_opcode"}, 64'(cap_be(h + 20, 2)), 64'(v.e_opc));
            chk({tag, "_spa"}, 64'(cap_be(h + 28, 4)), 64'(LIP));
            chk({tag, "_tha"}, 64'(cap_be(h + 32, 6)), 64'(v.e_tha));
            chk({tag, "_tpa"}, 64'(cap_be(h + 38, 4)), 64'(v.e_tpa));
            chk({tag, "_fcs"}, 64'({cap[n-1], cap[n-2], cap[n-3], cap[n-4]}),
                64'({gold[n-1], gold[n-2], gold[n-3], gold[n-4]}));
            c = 32'hFFFF_FFFF;
            for (int i = h; i < n; i++) c = crc_upd(c, cap[i]);
            for (int k = 0; k < 32; k++) rev[k] = c[31 - k];
            chk({tag, "_residue"}, 64'(rev), 64'hC704_DD7B);
        end
    endtask

    task automatic start(input vec_t v);
        int t;
        bus.arp_tx_op   = v.op;  bus_s.arp_tx_op = v.op;
        bus.des_mac     = v.dmac; bus_s.des_mac  = v.dmac;
        bus.des_ip      = v.dip;  bus_s.des_ip   = v.dip;
        t = 0;
        while (!mon_ready && t < 100) begin @(negedge arp_tx_clk); t++; end
        chk("ready_before_start", 64'(mon_ready), 64'h1);
        if (sel) bus_s.arp_tx_en = 1'b1; else bus.arp_tx_en = 1'b1;
        @(negedge arp_tx_clk);
        bus.arp_tx_en   = 1'b0;
        bus_s.arp_tx_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, seen;
        vecs[0] = '{2'd1, 48'h1234_5678_9ABC, 32'hC0A8_0010,
                    48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'hC0A8_0010};
        vecs[1] = '{2'd0, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0022,
                    48'hA0B1_C2D3_E4F5, 16'h0002, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0022};
        vecs[2] = '{2'd2, 48'h5566_7788_99AA, 32'h0A0B_0C0D,
                    48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'hC0A8_0003};
        vecs[3] = '{2'd3, 48'h0102_0304_0506, 32'h0A00_0001,
                    48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'h0A00_0001};

        n_cmp = 0; n_fail = 0; sel = 1'b0; rstn = 1'b0;
        bus.arp_tx_en = 1'b0; bus.arp_tx_op = 2'd0; bus.des_mac = '0; bus.des_ip = '0;
        bus.local_mac = LMAC; bus.local_ip = LIP;
        bus_s.arp_tx_en = 1'b0; bus_s.arp_tx_op = 2'd0; bus_s.des_mac = '0; bus_s.des_ip = '0;
        bus_s.local_mac = LMAC; bus_s.local_ip = LIP;

        // Reset with a start request asserted: it must be ignored
        repeat (3) @(negedge arp_tx_clk);
        bus.arp_tx_en = 1'b1;
        repeat (2) @(negedge arp_tx_clk);
        chk("reset_state", 64'({mon_ready, mon_busy, mon_valid, mon_done, mon_data, mon_cnt}), 64'h0);
        bus.arp_tx_en = 1'b0;
        rstn = 1'b1;
        @(negedge arp_tx_clk);
        chk("ready_after_release", 64'({mon_ready, mon_busy, mon_valid}), 64'h4);

        for (int i = 0; i < 4; i++) begin
            start(vecs[i]);
            capture();
            check_frame($sformatf("vec%0d", i), vecs[i], 7, 18);
            chk("frame_cnt", 64'(mon_cnt), 64'(i + 1));
        end

        // Back-to-back with en held: IFG idle cycles plus the accept cycle between frames
        t = 0;
        while (!mon_ready && t < 100) begin @(negedge arp_tx_clk); t++; end
        bus.arp_tx_op = vecs[0].op; bus.des_mac = vecs[0].dmac; bus.des_ip = vecs[0].dip;
        bus.arp_tx_en = 1'b1;
        capture();
        check_frame("b2b_first", vecs[0], 7, 18);
        t = 0;
        while (!mon_valid && t < 100) begin @(negedge arp_tx_clk); t++; end
        chk("b2b_gap_cycles", 64'(t), 64'(IFG + 1));
        fork
            capture();
            begin
                repeat (2) @(negedge arp_tx_clk);
                bus.arp_tx_en = 1'b0;
                bus.arp_tx_op = 2'd0; bus.des_mac = 48'hFFEE_DDCC_BBAA; bus.des_ip = 32'h0102_0304;
                bus.local_mac = 48'hAABB_CCDD_EEFF; bus.local_ip = 32'h0A0A_0A0A;
                repeat (10) @(negedge arp_tx_clk);
                bus.arp_tx_en = 1'b1;
                @(negedge arp_tx_clk);
                bus.arp_tx_en = 1'b0;
                repeat (20) @(negedge arp_tx_clk);
                bus.arp_tx_en = 1'b1;
                @(negedge arp_tx_clk);
                bus.arp_tx_en = 1'b0;
            end
        join
        check_frame("b2b_second", vecs[0], 7, 18);
        chk("b2b_frame_cnt", 64'(mon_cnt), 64'd6);
        bus.local_mac = LMAC; bus.local_ip = LIP;
        seen = 0;
        repeat (IFG + 10) begin
            @(negedge arp_tx_clk);
            if (mon_valid) seen++;
        end
        chk("no_queued_frame", 64'(seen), 64'h0);
        chk("idle_not_busy", 64'({mon_ready, mon_busy}), 64'h2);

        // Reset while byte 30 is on the wire
        start(vecs[2]);
        repeat (30) @(negedge arp_tx_clk);
        chk("byte30_valid", 64'(mon_valid), 64'h1);
        rstn = 1'b0;
        @(negedge arp_tx_clk);
        chk("abort_outputs", 64'({mon_ready, mon_busy, mon_valid, mon_done, mon_data, mon_cnt}), 64'h0);
        rstn = 1'b1;
        @(negedge arp_tx_clk);
        chk("abort_ready_back", 64'(mon_ready), 64'h1);
        start(vecs[1]);
        capture();
        check_frame("after_abort", vecs[1], 7, 18);
        chk("after_abort_cnt", 64'(mon_cnt), 64'h1);

        // Minimal-parameter instance: 1 preamble byte, no pad, 1 IFG cycle
        sel = 1'b1;
        start(vecs[0]);
        capture();
        check_frame("small", vecs[0], 1, 0);
        chk("small_sfd", 64'(cap[1]), 64'hD5);
        chk("small_cnt", 64'(mon_cnt), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
